// File: rtl/toy_bpu_rob_filter.sv
// Fetch ROB filter: tracks allocated fetch entries with write/ack/read
// pointers, routes icache acks to entries in order, drains completed
// entries in order into a one-entry output register, and discards
// entries marked invalid. Flush drops every unread entry while keeping
// slots with outstanding icache requests reserved until their acks return.

package toy_pack;
  parameter int FETCH_DATA_WIDTH = 32;
endpackage

module toy_bpu_rob_filter
  import toy_pack::*;
#(
  parameter int ENTRY_NUM = 4,
  parameter int IDX_W     = $clog2(ENTRY_NUM)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  alloc_vld,
  output logic                                  alloc_rdy,
  output logic [ENTRY_NUM-1:0]                  icache_prealloc,
  input  logic                                  icache_ack_vld,
  output logic [ENTRY_NUM-1:0]                  icache_ack_sel,
  input  logic [ENTRY_NUM-1:0]                  rob_entry_valid,
  input  logic [ENTRY_NUM-1:0]                  rob_entry_invalid,
  input  logic [ENTRY_NUM*FETCH_DATA_WIDTH-1:0] filter_pld,
  output logic [ENTRY_NUM-1:0]                  filter_rden,
  output logic [ENTRY_NUM-1:0]                  filter_bypass,
  input  logic                                  fe_ctrl_flush,
  output logic                                  out_vld,
  input  logic                                  out_rdy,
  output logic [FETCH_DATA_WIDTH-1:0]           out_pld,
  output logic [IDX_W-1:0]                      out_idx,
  output logic                                  ack_err
);

  // rst_n is active-high despite its name.
  localparam int PW = IDX_W + 1;
  localparam logic [PW-1:0] ENTRY_CNT = PW'(ENTRY_NUM);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);

  logic [PW-1:0] wptr, aptr, rptr;
  logic [PW-1:0] used_r, used_a;
  logic [IDX_W-1:0] w_idx, a_idx, h_idx;
  logic head_present, head_inv, head_val;
  logic alloc_fire, ack_fire, ack_bad, bypass_fire, read_fire;
  logic [FETCH_DATA_WIDTH-1:0] head_pld;

  assign used_r = wptr - rptr;
  assign used_a = wptr - aptr;
  assign w_idx  = wptr[IDX_W-1:0];
  assign a_idx  = aptr[IDX_W-1:0];
  assign h_idx  = rptr[IDX_W-1:0];

  // A slot is reusable only once it has been both read out and acked;
  // after a flush the ack pointer can lag the read pointer.
  assign alloc_rdy  = ~rst_n & ~fe_ctrl_flush & (used_r < ENTRY_CNT) & (used_a < ENTRY_CNT);
  assign alloc_fire = alloc_vld & alloc_rdy;

  // Acks are still honoured during a flush so the outstanding count stays exact.
  assign ack_fire = ~rst_n & icache_ack_vld & (aptr != wptr);
  assign ack_bad  = icache_ack_vld & (aptr == wptr);

  assign head_present = rptr != wptr;
  assign head_inv     = head_present & rob_entry_invalid[h_idx];
  assign head_val     = head_present & ~rob_entry_invalid[h_idx] & rob_entry_valid[h_idx];
  assign bypass_fire  = ~rst_n & ~fe_ctrl_flush & head_inv;
  assign read_fire    = ~rst_n & ~fe_ctrl_flush & head_val & (~out_vld | out_rdy);

  // Select the head entry's payload from the flattened per-entry bus.
  always_comb begin
    head_pld = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (IDX_W'(i) == h_idx) head_pld = filter_pld[i*FETCH_DATA_WIDTH +: FETCH_DATA_WIDTH];
    end
  end

  // One-hot strobes; each is a single decoded bit or all zero.
  always_comb begin
    icache_prealloc = '0;
    icache_ack_sel  = '0;
    filter_rden     = '0;
    filter_bypass   = '0;
    if (alloc_fire)  icache_prealloc[w_idx] = 1'b1;
    if (ack_fire)    icache_ack_sel[a_idx]  = 1'b1;
    if (read_fire)   filter_rden[h_idx]     = 1'b1;
    if (bypass_fire) filter_bypass[h_idx]   = 1'b1;
  end

  // Pointer, output register and sticky error update.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      wptr    <= '0;
      aptr    <= '0;
      rptr    <= '0;
      out_vld <= 1'b0;
      out_pld <= '0;
      out_idx <= '0;
      ack_err <= 1'b0;
    end else begin
      if (alloc_fire) wptr <= wptr + PTR_ONE;
      if (ack_fire)   aptr <= aptr + PTR_ONE;
      if (ack_bad)    ack_err <= 1'b1;
      if (fe_ctrl_flush) begin
        rptr    <= wptr;
        out_vld <= 1'b0;
      end else begin
        if (bypass_fire || read_fire) rptr <= rptr + PTR_ONE;
        if (read_fire) begin
          out_vld <= 1'b1;
          out_pld <= head_pld;
          out_idx <= h_idx;
        end else if (out_rdy) begin
          out_vld <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_toy_bpu_rob_filter.sv
// Bench for toy_bpu_rob_filter: directed vector table, a flush corner
// sequence, then random traffic against a count-based reference model.

module tb_toy_bpu_rob_filter;
  import toy_pack::*;

  localparam int E  = 4;
  localparam int FW = FETCH_DATA_WIDTH;

  logic clk = 1'b0;
  logic rst, av, kv, fl, rdy;
  logic [E-1:0] vl, iv;
  logic [E*FW-1:0] pld;
  logic alloc_rdy, out_vld, ack_err;
  logic [E-1:0] prealloc, ack_sel, rden, bypass;
  logic [FW-1:0] out_pld;
  logic [1:0] out_idx;

  int n_chk = 0;
  int n_err = 0;

  // reference model state: unbounded counts of allocs, acks, retirements
  int wc, ac, rc;
  logic m_ovld, m_aerr;
  logic [FW-1:0] m_opld;
  int m_oidx;

  always #5 clk = ~clk;

  toy_bpu_rob_filter #(.ENTRY_NUM(E)) dut (
    .clk(clk), .rst_n(rst), .alloc_vld(av), .alloc_rdy(alloc_rdy),
    .icache_prealloc(prealloc), .icache_ack_vld(kv), .icache_ack_sel(ack_sel),
    .rob_entry_valid(vl), .rob_entry_invalid(iv), .filter_pld(pld),
    .filter_rden(rden), .filter_bypass(bypass), .fe_ctrl_flush(fl),
    .out_vld(out_vld), .out_rdy(rdy), .out_pld(out_pld), .out_idx(out_idx),
    .ack_err(ack_err)
  );

  typedef struct packed {
    logic rst, av, kv, fl, rdy;
    logic [3:0] vl, iv;
    logic ardy;
    logic [3:0] pre, sel, rden, byp;
    logic ovld;
    logic [1:0] oidx;
    logic aerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic a, logic k, logic f, logic y, logic [3:0] vv, logic [3:0] ii,
                             logic ar, logic [3:0] p, logic [3:0] s, logic [3:0] rd, logic [3:0] b,
                             logic ov, logic [1:0] oi, logic ae);
    vec_t t;
    t.rst = r; t.av = a; t.kv = k; t.fl = f; t.rdy = y; t.vl = vv; t.iv = ii;
    t.ardy = ar; t.pre = p; t.sel = s; t.rden = rd; t.byp = b; t.ovld = ov; t.oidx = oi; t.aerr = ae;
    return t;
  endfunction

  function automatic logic [FW-1:0] pt(int i);
    return 32'hCAFE_0000 + 32'(i);
  endfunction

  function automatic logic [3:0] oh(int i);
    logic [3:0] b;
    b = 4'b0001;
    return b << i;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    wc = 0; ac = 0; rc = 0;
    m_ovld = 1'b0; m_aerr = 1'b0; m_opld = '0; m_oidx = 0;
  endtask

  // Called at negedge: compare DUT against model for current inputs, then advance model.
  task automatic model_step();
    logic [3:0] e_pre, e_sel, e_rden, e_byp;
    logic e_ardy;
    int h;
    e_pre = '0; e_sel = '0; e_rden = '0; e_byp = '0; e_ardy = 1'b0;
    h = rc % E;
    if (!rst) begin
      e_ardy = !fl && (wc - rc < E) && (wc - ac < E);
      if (av && e_ardy) e_pre = oh(wc % E);
      if (kv && ac < wc) e_sel = oh(ac % E);
      if (!fl && rc < wc) begin
        if (iv[h]) e_byp = oh(h);
        else if (vl[h] && (!m_ovld || rdy)) e_rden = oh(h);
      end
    end
    chk("m_alloc_rdy", 64'(alloc_rdy), 64'(e_ardy));
    chk("m_prealloc",  64'(prealloc),  64'(e_pre));
    chk("m_ack_sel",   64'(ack_sel),   64'(e_sel));
    chk("m_rden",      64'(rden),      64'(e_rden));
    chk("m_bypass",    64'(bypass),    64'(e_byp));
    chk("m_out_vld",   64'(out_vld),   64'(m_ovld));
    chk("m_out_pld",   64'(out_pld),   64'(m_opld));
    chk("m_out_idx",   64'(out_idx),   64'(m_oidx));
    chk("m_ack_err",   64'(ack_err),   64'(m_aerr));
    if (rst) begin
      model_reset();
    end else begin
      if (kv && ac == wc) m_aerr = 1'b1;
      if (e_pre != 0) wc++;
      if (e_sel != 0) ac++;
      if (fl) begin
        rc = wc;
        m_ovld = 1'b0;
      end else begin
        if (e_byp != 0 || e_rden != 0) rc++;
        if (e_rden != 0) begin
          m_ovld = 1'b1;
          m_opld = pld[h*FW +: FW];
          m_oidx = h;
        end else if (rdy) begin
          m_ovld = 1'b0;
        end
      end
    end
  endtask

  task automatic finish_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic hstep(input string nm, input logic [3:0] e_pre, input logic [3:0] e_sel,
                       input logic [3:0] e_rden, input logic [3:0] e_byp, input logic e_ardy, input logic e_ovld);
    @(negedge clk);
    chk({nm, "_pre"},  64'(prealloc),  64'(e_pre));
    chk({nm, "_sel"},  64'(ack_sel),   64'(e_sel));
    chk({nm, "_rden"}, 64'(rden),      64'(e_rden));
    chk({nm, "_byp"},  64'(bypass),    64'(e_byp));
    chk({nm, "_ardy"}, 64'(alloc_rdy), 64'(e_ardy));
    chk({nm, "_ovld"}, 64'(out_vld),   64'(e_ovld));
    finish_cycle();
  endtask

  task automatic set_in(input logic r, input logic a, input logic k, input logic f, input logic y,
                        input logic [3:0] vv, input logic [3:0] ii);
    rst = r; av = a; kv = k; fl = f; rdy = y; vl = vv; iv = ii;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    set_in(1, 0, 0, 0, 0, 4'b0, 4'b0);
    for (int i = 0; i < E; i++) pld[i*FW +: FW] = pt(i);
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // directed table: alloc to full, in-order drain, invalid bypass, bad ack + backpressure
    //           rst a k f y  vl       iv       ardy pre      sel      rden     byp      ov oi ae
    tbl.push_back(v(1,0,0,0,0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0,1,0,0,0, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0,1,0,0,0, 4'b0000, 4'b0000, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0,1,0,0,0, 4'b0000, 4'b0000, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0,1,0,0,0, 4'b0000, 4'b0000, 1, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0,1,0,0,0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0,0,1,0,0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0,0,1,0,0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0,0,0,0,1, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0,0,0,0,1, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1, 0, 0));
    tbl.push_back(v(0,0,0,0,1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0));
    tbl.push_back(v(0,0,0,0,1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1,0,0,0,0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0,1,0,0,0, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0,1,0,0,0, 4'b0000, 4'b0000, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0,0,0,0,1, 4'b0010, 4'b0001, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 0, 0, 0));
    tbl.push_back(v(0,0,0,0,1, 4'b0010, 4'b0001, 1, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0,0,0,0,1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0));
    tbl.push_back(v(0,0,0,0,1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(1,0,0,0,0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0,0,1,0,0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(v(0,0,0,0,0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1));
    tbl.push_back(v(0,1,0,0,0, 4'b0000, 4'b0000, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1));
    tbl.push_back(v(0,1,0,0,0, 4'b0000, 4'b0000, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1));
    tbl.push_back(v(0,0,1,0,0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 0, 1));
    tbl.push_back(v(0,0,1,0,0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 0, 0, 1));
    tbl.push_back(v(0,0,0,0,0, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 0, 0, 1));
    tbl.push_back(v(0,0,0,0,0, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1));
    tbl.push_back(v(0,0,0,0,0, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 0, 1));
    tbl.push_back(v(0,0,0,0,1, 4'b0011, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1, 0, 1));
    tbl.push_back(v(0,0,0,0,1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 1, 1));
    tbl.push_back(v(0,0,0,0,1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1));
    tbl.push_back(v(1,0,0,0,0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 1));
    tbl.push_back(v(0,0,0,0,0, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].rst, tbl[i].av, tbl[i].kv, tbl[i].fl, tbl[i].rdy, tbl[i].vl, tbl[i].iv);
      @(negedge clk);
      chk($sformatf("t%0d_alloc_rdy", i), 64'(alloc_rdy), 64'(tbl[i].ardy));
      chk($sformatf("t%0d_prealloc", i),  64'(prealloc),  64'(tbl[i].pre));
      chk($sformatf("t%0d_ack_sel", i),   64'(ack_sel),   64'(tbl[i].sel));
      chk($sformatf("t%0d_rden", i),      64'(rden),      64'(tbl[i].rden));
      chk($sformatf("t%0d_bypass", i),    64'(bypass),    64'(tbl[i].byp));
      chk($sformatf("t%0d_out_vld", i),   64'(out_vld),   64'(tbl[i].ovld));
      chk($sformatf("t%0d_ack_err", i),   64'(ack_err),   64'(tbl[i].aerr));
      if (tbl[i].ovld) begin
        chk($sformatf("t%0d_out_idx", i), 64'(out_idx), 64'(tbl[i].oidx));
        chk($sformatf("t%0d_out_pld", i), 64'(out_pld), 64'(pt(int'(tbl[i].oidx))));
      end
      finish_cycle();
    end

    // flush with acks outstanding: 3 allocs, 1 ack, flush, 2 late acks, refill to full
    set_in(0, 1, 0, 0, 0, 4'b0000, 4'b0000); hstep("f_alloc0", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    hstep("f_alloc1", 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    hstep("f_alloc2", 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    set_in(0, 0, 1, 0, 0, 4'b0000, 4'b0000); hstep("f_ack0", 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1, 0);
    set_in(0, 1, 0, 1, 1, 4'b1111, 4'b1111); hstep("f_flush", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);
    set_in(0, 0, 1, 0, 1, 4'b1111, 4'b0000); hstep("f_ack1", 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1, 0);
    set_in(0, 0, 1, 0, 1, 4'b0000, 4'b0000); hstep("f_ack2", 4'b0000, 4'b0100, 4'b0000, 4'b0000, 1, 0);
    set_in(0, 1, 0, 0, 1, 4'b0000, 4'b0000); hstep("f_re0", 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    hstep("f_re1", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    hstep("f_re2", 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    hstep("f_re3", 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 0);
    hstep("f_full", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0);

    // random traffic against the model
    set_in(1, 0, 0, 0, 0, 4'b0000, 4'b0000);
    finish_cycle();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      fl  = ($urandom_range(0, 15) == 0);
      av  = ($urandom_range(0, 9) < 6);
      kv  = ($urandom_range(0, 9) < 5);
      rdy = ($urandom_range(0, 9) < 7);
      vl  = 4'($urandom);
      iv  = 4'($urandom & $urandom & $urandom);
      for (int i = 0; i < E; i++) pld[i*FW +: FW] = $urandom;
      @(negedge clk);
      finish_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
